// File: rtl/reset_sequencer.sv
// reset_sequencer: holds N_CH DUT channels in active-low reset for HOLD_CYCLES,
// releases them STAGGER cycles apart, then counts run cycles until every
// channel reports done (DONE) or the optional run limit expires (TIMEOUT).
// Optional build macro RSTSEQ_TRACE_EN adds done_cycle_o, which records the
// run cycle on which each channel's done was latched.
module reset_sequencer #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 50,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic [N_CH-1:0]        done_i,
    output logic [N_CH-1:0]        rst_n_o,
    output logic                   running_o,
    output logic                   all_done_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycle_cnt_o
`ifdef RSTSEQ_TRACE_EN
    ,
    output logic [N_CH*CNT_W-1:0]  done_cycle_o
`endif
);

    // One counter serves both the hold phase and the stagger gaps.
    localparam int HC_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;

    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0]  STG_LAST  = HC_W'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t          state;
    logic [HC_W-1:0] hcnt;
    logic [N_CH-1:0] sticky;
    logic [N_CH-1:0] sticky_nxt;
    logic [N_CH-1:0] rel_next;
    logic            cnt_max;

    // Done is only honoured on channels that are already out of reset.
    assign sticky_nxt = sticky | (done_i & rst_n_o);
    // Thermometer fill: each release step raises the next channel up.
    assign rel_next   = (rst_n_o << 1) | N_CH'(1);
    assign cnt_max    = &cycle_cnt_o;

    // Main sequencer: state, channel resets, run counter and status flags.
    always_ff @(posedge clk) begin
        if (rst || req_i) begin
            state       <= S_HOLD;
            hcnt        <= '0;
            sticky      <= '0;
            rst_n_o     <= '0;
            running_o   <= 1'b0;
            all_done_o  <= 1'b0;
            timeout_o   <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hcnt == HOLD_LAST) begin
                        hcnt <= '0;
                        if (N_CH == 1 || STAGGER == 0) begin
                            rst_n_o   <= '1;
                            state     <= S_RUN;
                            running_o <= 1'b1;
                        end else begin
                            rst_n_o <= N_CH'(1);
                            state   <= S_RELEASE;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (hcnt == STG_LAST) begin
                        hcnt    <= '0;
                        rst_n_o <= rel_next;
                        if (&rel_next) begin
                            state     <= S_RUN;
                            running_o <= 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    sticky <= sticky_nxt;
                    if (&sticky_nxt) begin
                        // Completion edge still counts; the value then freezes.
                        state      <= S_DONE;
                        running_o  <= 1'b0;
                        all_done_o <= 1'b1;
                        if (!cnt_max) cycle_cnt_o <= cycle_cnt_o + 1'b1;
                    end else if (TIMEOUT != 0 && cycle_cnt_o == TO_LAST) begin
                        state     <= S_TIMEOUT;
                        running_o <= 1'b0;
                        timeout_o <= 1'b1;
                        rst_n_o   <= '0;
                    end else if (!cnt_max) begin
                        cycle_cnt_o <= cycle_cnt_o + 1'b1;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    // Terminal: hold everything until req_i or rst.
                end
                default: state <= S_HOLD;
            endcase
        end
    end

`ifdef RSTSEQ_TRACE_EN
    logic [N_CH-1:0][CNT_W-1:0] done_cycle;

    // Snapshot the run count on the cycle each channel's sticky bit first sets.
    always_ff @(posedge clk) begin
        if (rst || req_i) begin
            done_cycle <= '0;
        end else if (state == S_RUN) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sticky_nxt[k] && !sticky[k]) done_cycle[k] <= cycle_cnt_o;
            end
        end
    end

    assign done_cycle_o = done_cycle;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: four instances (defaults, TIMEOUT=100,
// STAGGER=0, CNT_W=4) share clk/rst/req_i; expected values are hand-computed.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [3:0] done_def = 4'b0000;
    logic [3:0] done_to  = 4'b0001;
    logic [3:0] done_s0  = 4'b1111;
    logic [3:0] done_c4  = 4'b0000;

    logic [3:0]  rn  [4];
    logic        run [4];
    logic        ad  [4];
    logic        tmo [4];
    logic [15:0] cnt_def, cnt_to, cnt_s0;
    logic [3:0]  cnt_c4;
`ifdef RSTSEQ_TRACE_EN
    logic [63:0] dc_def, dc_to, dc_s0;
    logic [15:0] dc_c4;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    always #5 clk = ~clk;

    reset_sequencer u_def (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done_def),
        .rst_n_o(rn[0]), .running_o(run[0]), .all_done_o(ad[0]), .timeout_o(tmo[0]),
        .cycle_cnt_o(cnt_def)
`ifdef RSTSEQ_TRACE_EN
        , .done_cycle_o(dc_def)
`endif
    );

    reset_sequencer #(.TIMEOUT(100)) u_to (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done_to),
        .rst_n_o(rn[1]), .running_o(run[1]), .all_done_o(ad[1]), .timeout_o(tmo[1]),
        .cycle_cnt_o(cnt_to)
`ifdef RSTSEQ_TRACE_EN
        , .done_cycle_o(dc_to)
`endif
    );

    reset_sequencer #(.STAGGER(0)) u_s0 (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done_s0),
        .rst_n_o(rn[2]), .running_o(run[2]), .all_done_o(ad[2]), .timeout_o(tmo[2]),
        .cycle_cnt_o(cnt_s0)
`ifdef RSTSEQ_TRACE_EN
        , .done_cycle_o(dc_s0)
`endif
    );

    reset_sequencer #(.CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done_c4),
        .rst_n_o(rn[3]), .running_o(run[3]), .all_done_o(ad[3]), .timeout_o(tmo[3]),
        .cycle_cnt_o(cnt_c4)
`ifdef RSTSEQ_TRACE_EN
        , .done_cycle_o(dc_c4)
`endif
    );

    typedef struct {
        int         at;
        int         dut;
        logic [3:0] rst_n;
        logic       run;
        logic       ad;
        logic       tmo;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int at, input int dut, input logic [3:0] rst_n,
                       input logic r, input logic a, input logic t, input int cnt);
        vec_t v;
        v.at = at; v.dut = dut; v.rst_n = rst_n; v.run = r; v.ad = a; v.tmo = t; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    endtask

    function automatic int cnt_of(input int d);
        case (d)
            0: return int'(cnt_def);
            1: return int'(cnt_to);
            2: return int'(cnt_s0);
            default: return int'(cnt_c4);
        endcase
    endfunction

    task automatic check_vec(input vec_t v);
        string tag;
        tag = $sformatf("d%0d@%0d", v.dut, v.at);
        check({tag, ".rst_n"},    int'(rn[v.dut]),  int'(v.rst_n));
        check({tag, ".running"},  int'(run[v.dut]), int'(v.run));
        check({tag, ".all_done"}, int'(ad[v.dut]),  int'(v.ad));
        check({tag, ".timeout"},  int'(tmo[v.dut]), int'(v.tmo));
        check({tag, ".cnt"},      cnt_of(v.dut),    v.cnt);
    endtask

    task automatic apply_checks(input int e);
        foreach (vecs[i]) if (vecs[i].at == e) check_vec(vecs[i]);
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    initial begin
        // Defaults: staggered release 50/54/58/62, then done on run cycles 10,20,30,40.
        add(0,   0, 4'b0000, 0, 0, 0, 0);
        add(49,  0, 4'b0000, 0, 0, 0, 0);
        add(50,  0, 4'b0001, 0, 0, 0, 0);
        add(53,  0, 4'b0001, 0, 0, 0, 0);
        add(54,  0, 4'b0011, 0, 0, 0, 0);
        add(58,  0, 4'b0111, 0, 0, 0, 0);
        add(61,  0, 4'b0111, 0, 0, 0, 0);
        add(62,  0, 4'b1111, 1, 0, 0, 0);
        add(63,  0, 4'b1111, 1, 0, 0, 1);
        add(72,  0, 4'b1111, 1, 0, 0, 10);
        add(102, 0, 4'b1111, 1, 0, 0, 40);
        add(103, 0, 4'b1111, 0, 1, 0, 41);
        add(120, 0, 4'b1111, 0, 1, 0, 41);
        // TIMEOUT=100, only ch0 done.
        add(0,   1, 4'b0000, 0, 0, 0, 0);
        add(161, 1, 4'b1111, 1, 0, 0, 99);
        add(162, 1, 4'b0000, 0, 0, 1, 99);
        add(170, 1, 4'b0000, 0, 0, 1, 99);
        // STAGGER=0, done held high from the start.
        add(49,  2, 4'b0000, 0, 0, 0, 0);
        add(50,  2, 4'b1111, 1, 0, 0, 0);
        add(51,  2, 4'b1111, 0, 1, 0, 1);
        // CNT_W=4 saturation.
        add(76,  3, 4'b1111, 1, 0, 0, 14);
        add(77,  3, 4'b1111, 1, 0, 0, 15);
        add(78,  3, 4'b1111, 1, 0, 0, 15);
        add(150, 3, 4'b1111, 1, 0, 0, 15);

        repeat (5) @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
        apply_checks(0);

        for (int e = 1; e <= 170; e++) begin
            tick();
            apply_checks(edge_n);
            // Done stimulus for the default instance; ch0 drops after latching.
            case (edge_n)
                72:  done_def = 4'b0001;
                80:  done_def = 4'b0000;
                82:  done_def = 4'b0100;
                92:  done_def = 4'b0110;
                102: done_def = 4'b1110;
                default: ;
            endcase
`ifdef RSTSEQ_TRACE_EN
            if (edge_n == 103) begin
                check("trace.ch0", int'(dc_def[15:0]),  10);
                check("trace.ch1", int'(dc_def[31:16]), 30);
                check("trace.ch2", int'(dc_def[47:32]), 20);
                check("trace.ch3", int'(dc_def[63:48]), 40);
            end
`endif
        end

        // Restart via req_i in the middle of the release sequence.
        done_def = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        edge_n = 0;
        for (int e = 1; e <= 125; e++) begin
            tick();
            if (edge_n == 55) begin
                check("req.pre_rst_n", int'(rn[0]), 4'b0011);
                check("req.s0_done_before", int'(ad[2]), 1);
                req = 1'b1;
            end
            if (edge_n == 56) begin
                req = 1'b0;
                check("req.rst_n_cleared", int'(rn[0]), 4'b0000);
                check("req.s0_done_cleared", int'(ad[2]), 0);
                check("req.s0_cnt_cleared", int'(cnt_s0), 0);
`ifdef RSTSEQ_TRACE_EN
                check("req.s0_trace_cleared", int'(dc_s0[15:0]), 0);
`endif
            end
            if (edge_n == 105) check("req.hold_105", int'(rn[0]), 4'b0000);
            if (edge_n == 106) check("req.rerelease_106", int'(rn[0]), 4'b0001);
            if (edge_n == 110) check("req.rerelease_110", int'(rn[0]), 4'b0011);
            if (edge_n == 107) begin
                check("req.s0_done_again", int'(ad[2]), 1);
                check("req.s0_cnt_again", int'(cnt_s0), 1);
            end
            if (edge_n == 125) begin
                check("run.cnt_125", int'(cnt_def), 7);
                check("run.running_125", int'(run[0]), 1);
            end
        end

        // Synchronous reset while running.
        rst = 1'b1;
        tick();
        check("rst.rst_n", int'(rn[0]), 4'b0000);
        check("rst.running", int'(run[0]), 0);
        check("rst.cnt", int'(cnt_def), 0);
        check("rst.timeout", int'(tmo[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
